// File: rtl/flappy_btn_pulser_pkg.sv
// Shared state encoding, button indices and sizing helper for the push-button pulser.
package flappy_btn_pkg;

    typedef enum logic [2:0] {
        INI  = 3'd0,
        WQ   = 3'd1,
        SCEN = 3'd2,
        CCR  = 3'd3,
        WFCR = 3'd4
    } btn_state_t;

    localparam int BTN_C = 0;
    localparam int BTN_R = 1;
    localparam int BTN_D = 2;
    localparam int BTN_U = 3;
    localparam int BTN_L = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/flappy_btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, saturating counter and debounce FSM.
// Auto-repeat is built only when FLAPPY_BTN_REPEAT_EN is defined.
module flappy_btn_debounce_ch
    import flappy_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic board_clk,
    input  logic Reset,
    input  logic btn_raw,
    output logic level,
    output logic pulse
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_ff;
    logic             sync;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             rep_hit;
    btn_state_t       state;

    assign sync    = sync_ff[1];
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef FLAPPY_BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic first_done;

    assign rep_hit = first_done ? (cnt == RP_LAST) : (cnt == RD_LAST);

    // Selects the long first-repeat delay until one repeat has fired in this press.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset)
            first_done <= 1'b0;
        else if (state == CCR && sync && rep_hit)
            first_done <= 1'b1;
        else if (state == WFCR && !sync && cnt == DB_LAST)
            first_done <= 1'b0;
    end
`else
    assign rep_hit = 1'b0;
`endif

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            sync_ff <= '0;
            cnt     <= '0;
            state   <= INI;
            level   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], btn_raw};
            level   <= (state == SCEN) || (state == CCR) || (state == WFCR);
            pulse   <= (state == SCEN) || (state == CCR && sync && rep_hit);
            case (state)
                INI: begin
                    if (sync) begin
                        state <= WQ;
                        cnt   <= CNT_W'(1);
                    end
                end
                WQ: begin
                    if (!sync)                state <= INI;
                    else if (cnt == DB_LAST)  state <= SCEN;
                    else                      cnt   <= cnt_inc;
                end
                SCEN: begin
                    state <= CCR;
                    cnt   <= '0;
                end
                CCR: begin
                    if (!sync) begin
                        state <= WFCR;
                        cnt   <= CNT_W'(1);
                    end else if (rep_hit) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WFCR: begin
                    // A bounce back high returns to held without a new pulse.
                    if (sync) begin
                        state <= CCR;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= INI;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= INI;
            endcase
        end
    end

endmodule

// File: rtl/flappy_btn_pulser.sv
// Debounced level and press strobe for the Nexys push-buttons, one channel per bit.
// Optional auto-repeat: define FLAPPY_BTN_REPEAT_EN.
module flappy_btn_pulser
    import flappy_btn_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic             board_clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        flappy_btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .board_clk(board_clk),
            .Reset    (Reset),
            .btn_raw  (btn_raw[i]),
            .level    (btn_level[i]),
            .pulse    (btn_pulse[i])
        );
    end

endmodule

// File: doc/flappy_btn_pulser.md
# flappy_btn_pulser

Debounces and synchronizes the five Nexys push-buttons (BtnC, BtnD, BtnU, BtnR, BtnL). For each button it produces a clean level and a single-`board_clk` press pulse. It sits between the board pins and the game core, and sources the `Start`, `Ack` and `Jump` pulses for `X_RAM_NOREAD`, `obstacle_logic` and `flight_physics`. Each button has its own independent debounce state machine.

## Interface
- `N_BTN`, default 5: number of button channels. Bit order is {BtnL, BtnU, BtnD, BtnR, BtnC}, MSB to LSB.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronized samples required to accept a press or a release (20 ms at 50 MHz). Must be ≥ 2.
- `REPEAT_DELAY`, default 25_000_000: held cycles before the first auto-repeat pulse. Used only with `FLAPPY_BTN_REPEAT_EN`.
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent auto-repeat pulses. Used only with `FLAPPY_BTN_REPEAT_EN`.
- `board_clk`  in  1  50 MHz system clock.
- `Reset`  in  1  asynchronous, active-high.
- `btn_raw`  in  N_BTN  raw, asynchronous button pins.
- `btn_level`  out  N_BTN  debounced button state, 1 = pressed.
- `btn_pulse`  out  N_BTN  one-cycle press strobe (also fires on auto-repeat).

## Operation
- Every output and every internal flop resets to 0. Each channel resets to state INI.
- Each channel first passes `btn_raw` through a 2-flop synchronizer; the output is `sync`. The FSM sees only `sync`.
- Each channel has one counter, `cnt`, of width `$clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1)`. `cnt` saturates and never wraps.
- FSM states per channel:
  - INI: `level`=0. If `sync`=1, go to WQ with `cnt`=1.
  - WQ (wait for stable press): `level`=0.
    - If `sync`=0, go to INI.
    - If `sync`=1 and `cnt`=DEBOUNCE_CYCLES-1, go to SCEN.
    - Otherwise increment `cnt`.
  - SCEN: `pulse`=1 and `level`=1 for exactly one cycle, then go to CCR with `cnt`=0.
  - CCR (held): `level`=1. If `sync`=0, go to WFCR with `cnt`=1. Otherwise increment `cnt` (used by auto-repeat).
  - WFCR (wait for stable release): `level`=1.
    - If `sync`=1, go to CCR with `cnt`=0. No new pulse is generated.
    - If `sync`=0 and `cnt`=DEBOUNCE_CYCLES-1, go to INI.
    - Otherwise increment `cnt`.
- `btn_pulse[i]` and `btn_level[i]` are registered outputs decoded from the state.
- Channels are fully independent. Simultaneous presses each produce their own pulse in the same cycle.
- Any glitch shorter than DEBOUNCE_CYCLES `sync` cycles produces no pulse and no level change.
- `Reset` asserted mid-press clears the outputs immediately. A button still held at deassertion is re-qualified from INI, so a single new pulse follows after the full debounce latency.
- `btn_pulse` is a `board_clk` strobe. Consumers clocked on slow `DIV_CLK` taps must use `btn_level`, or take the strobe through their own stretcher.

## Timing
- Raw rising edge first sampled at clock edge k, raw held high: `btn_pulse` and `btn_level` go high for the cycle after edge k+DEBOUNCE_CYCLES+2. Press latency is therefore DEBOUNCE_CYCLES+3 cycles.
- Raw falling edge first sampled at edge j, raw held low: `btn_level` goes low DEBOUNCE_CYCLES+3 cycles after edge j.
- `btn_pulse` width is exactly 1 cycle. Minimum spacing between two pulses on one channel, without repeat, is 2·DEBOUNCE_CYCLES+6 cycles.
- With repeat enabled: the first repeat pulse comes REPEAT_DELAY cycles after SCEN, then one pulse every REPEAT_PERIOD cycles while `sync` stays 1.

## Configuration
- `FLAPPY_BTN_REPEAT_EN` defined:
  - In CCR, `cnt`=REPEAT_DELAY-1 (first repeat) or REPEAT_PERIOD-1 (later repeats) produces a one-cycle `btn_pulse` and reloads `cnt`=0.
  - A 1-bit `first_done` flag per channel selects which threshold applies. The flag is cleared on leaving CCR through INI.
- `FLAPPY_BTN_REPEAT_EN` undefined: exactly one pulse per qualified press. Repeat logic and `first_done` are absent, and the REPEAT_* parameters are ignored.

## Structure
- Package `flappy_btn_pkg` holds:
  - the state encoding: INI, WQ, SCEN, CCR, WFCR (3-bit one-hot-safe enumeration);
  - button index constants BTN_C=0, BTN_R=1, BTN_D=2, BTN_U=3, BTN_L=4.
- Sub-module `flappy_btn_debounce_ch`: synchronizer, counter and FSM for one button. The top instantiates it N_BTN times in a generate loop; the top contains no other logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Clean press of BtnC for 20 cycles -> `btn_pulse[0]` high for exactly 1 cycle, 7 cycles after first sample. `btn_level[0]` high from the same cycle until 7 cycles after release.
- BtnU bounces 1-0-1-0 at 2-cycle intervals, then holds high -> no pulse during the bounce. Exactly one pulse arrives 7 cycles after the final rising sample.
- BtnD pressed, held, released with a 2-cycle low glitch mid-hold -> single pulse, `btn_level[2]` stays high through the glitch.
- BtnL and BtnC pressed on the same edge -> `btn_pulse[4]` and `btn_pulse[0]` high in the same cycle.
- `Reset` asserted 3 cycles into a BtnC hold and released while still held -> all outputs 0 during reset, then one pulse 7 cycles after release.
- `FLAPPY_BTN_REPEAT_EN` defined, BtnC held for 40 cycles -> pulses at cycle 7, 17, 22, 27, 32, 37 relative to first sample. With the macro undefined -> only the pulse at cycle 7.
